prog_clk_gen: RTL and testbench

Synthesizable multi-channel programmable clock/PWM generator that replaces the fixed-parameter behavioural clock generator. Each of CH channels divides the system clock by a runtime-programmable period with a programmable high time, so frequency and duty change without recompiling. New settings are double-buffered and take effect only at a period boundary, which keeps outputs glitch-free. Sits beside the test and peripheral logic as the source of derived clocks, strobes and PWM waveforms.

---
 rtl/prog_clk_gen_if.sv | 41 ++++
 rtl/prog_clk_gen.sv | 120 ++++++++++++
 tb/tb_prog_clk_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/prog_clk_gen_if.sv
// Configuration/status bundle for prog_clk_gen.
// The master drives enables and config writes; the slave (the generator) returns
// the error pulse, pending flags and generated waveforms.
// Optional CLKGEN_PHASE_SYNC_EN adds the phase-restart strobe 'sync'.
interface prog_clk_gen_if #(
    parameter int unsigned CH = 4,
    parameter int unsigned CW = 16
) ();
    localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]  enable;
    logic           cfg_wr;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_period;
    logic [CW-1:0]  cfg_high;
    logic           cfg_err;
    logic [CH-1:0]  pending;
    logic [CH-1:0]  clk_out;
    logic [CH-1:0]  wrap;
`ifdef CLKGEN_PHASE_SYNC_EN
    logic           sync;

    modport master (
        output enable, cfg_wr, cfg_ch, cfg_period, cfg_high, sync,
        input  cfg_err, pending, clk_out, wrap
    );
    modport slave (
        input  enable, cfg_wr, cfg_ch, cfg_period, cfg_high, sync,
        output cfg_err, pending, clk_out, wrap
    );
`else
    modport master (
        output enable, cfg_wr, cfg_ch, cfg_period, cfg_high,
        input  cfg_err, pending, clk_out, wrap
    );
    modport slave (
        input  enable, cfg_wr, cfg_ch, cfg_period, cfg_high,
        output cfg_err, pending, clk_out, wrap
    );
`endif
endinterface

// File: rtl/prog_clk_gen.sv
// Multi-channel programmable clock/PWM generator.
// Each channel divides clk by a runtime period with a programmable high time.
// Writes go to a shadow copy and are applied only at a period boundary (or at
// once while the channel is disabled), so outputs never glitch.
// Optional CLKGEN_PHASE_SYNC_EN: a 'sync' strobe forces every enabled channel to wrap.
module prog_clk_gen #(
    parameter int unsigned CH = 4,
    parameter int unsigned CW = 16
) (
    input logic          clk,
    input logic          rst,
    prog_clk_gen_if.slave bus
);
    localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CW-1:0] CntOne = CW'(1);
    localparam logic [CW-1:0] CntTwo = CW'(2);

    logic [CH-1:0][CW-1:0] act_period_q, act_period_d;
    logic [CH-1:0][CW-1:0] act_high_q, act_high_d;
    logic [CH-1:0][CW-1:0] sh_period_q, sh_period_d;
    logic [CH-1:0][CW-1:0] sh_high_q, sh_high_d;
    logic [CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CH-1:0][CW-1:0] cnt_inc;
    logic [CH-1:0]         pending_q, pending_d;
    logic [CH-1:0]         clk_out_q, clk_out_d;
    logic [CH-1:0]         wrap_q, wrap_d;
    logic [CH-1:0]         load;
    logic [CH-1:0]         wr_hit;
    logic                  cfg_err_q, cfg_err_d;
    logic                  wr_ok;

    // Validate a config write; rejected writes raise cfg_err for one cycle
    always_comb begin
        wr_ok = bus.cfg_wr && (32'(bus.cfg_ch) < CH) && (bus.cfg_period >= CntTwo) &&
                (bus.cfg_high >= CntOne) && (bus.cfg_high < bus.cfg_period);
        cfg_err_d = bus.cfg_wr && !wr_ok;
    end

    // Per-channel next state: shadow update, counting, boundary loads
    always_comb begin
        act_period_d = act_period_q;
        act_high_d   = act_high_q;
        sh_period_d  = sh_period_q;
        sh_high_d    = sh_high_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        clk_out_d    = clk_out_q;
        wrap_d       = wrap_q;
        load         = '0;
        wr_hit       = '0;
        cnt_inc      = '0;
        for (int i = 0; i < CH; i++) begin
            wr_hit[i]  = wr_ok && (bus.cfg_ch == CHW'(i));
            cnt_inc[i] = (cnt_q[i] == act_period_q[i] - CntOne) ? '0 : cnt_q[i] + CntOne;
            if (wr_hit[i]) begin
                sh_period_d[i] = bus.cfg_period;
                sh_high_d[i]   = bus.cfg_high;
            end
            if (!bus.enable[i]) begin
                // Idle: park counter so the first enabled edge starts a fresh period
                load[i]      = pending_q[i];
                clk_out_d[i] = 1'b0;
                wrap_d[i]    = 1'b0;
            end
`ifdef CLKGEN_PHASE_SYNC_EN
            else if (bus.sync) begin
                load[i]      = pending_q[i];
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b1;
                wrap_d[i]    = 1'b1;
            end
`endif
            else begin
                cnt_d[i]     = cnt_inc[i];
                wrap_d[i]    = (cnt_inc[i] == '0);
                load[i]      = pending_q[i] && wrap_d[i];
                clk_out_d[i] = cnt_inc[i] < (load[i] ? sh_high_q[i] : act_high_q[i]);
            end
            // The old shadow is applied here; a same-edge write stays pending
            if (load[i]) begin
                act_period_d[i] = sh_period_q[i];
                act_high_d[i]   = sh_high_q[i];
            end
            if (!bus.enable[i]) begin
                cnt_d[i] = act_period_d[i] - CntOne;
            end
            pending_d[i] = wr_hit[i] ? 1'b1 : (load[i] ? 1'b0 : pending_q[i]);
        end
    end

    // State registers with asynchronous reset to the 2-cycle, 50% default
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_period_q <= {CH{CntTwo}};
            act_high_q   <= {CH{CntOne}};
            sh_period_q  <= {CH{CntTwo}};
            sh_high_q    <= {CH{CntOne}};
            cnt_q        <= {CH{CntOne}};
            pending_q    <= '0;
            clk_out_q    <= '0;
            wrap_q       <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            sh_period_q  <= sh_period_d;
            sh_high_q    <= sh_high_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            clk_out_q    <= clk_out_d;
            wrap_q       <= wrap_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.cfg_err = cfg_err_q;
    assign bus.pending = pending_q;
    assign bus.clk_out = clk_out_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_prog_clk_gen.sv
// Directed bench for prog_clk_gen with CH=3 so that cfg_ch=CH is encodable.
// The sync test is built only when CLKGEN_PHASE_SYNC_EN is defined.
module tb_prog_clk_gen;
    localparam int unsigned CH = 3;
    localparam int unsigned CW = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    prog_clk_gen_if #(.CH(CH), .CW(CW)) bus ();

    prog_clk_gen #(.CH(CH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input int period, input int high);
        bus.cfg_wr     = 1'b1;
        bus.cfg_ch     = 2'(ch);
        bus.cfg_period = 16'(period);
        bus.cfg_high   = 16'(high);
    endtask

    task automatic clr_cfg();
        bus.cfg_wr = 1'b0;
    endtask

    // Check n edges of channel ch starting at counter phase first
    task automatic expect_run(input int ch, input int period, input int high,
                              input int first, input int n);
        int ph;
        for (int j = 0; j < n; j++) begin
            step();
            ph = (first + j) % period;
            check($sformatf("clk_out[%0d] ph%0d", ch, ph), 32'(bus.clk_out[ch]),
                  32'(ph < high));
            check($sformatf("wrap[%0d] ph%0d", ch, ph), 32'(bus.wrap[ch]), 32'(ph == 0));
        end
    endtask

    // Rejected write vectors: high=0, high=period, period=1, cfg_ch=CH
    int bad_ch[4]     = '{2, 2, 2, 3};
    int bad_period[4] = '{8, 8, 1, 8};
    int bad_high[4]   = '{0, 8, 1, 3};

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.enable     = '0;
        bus.cfg_wr     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_period = '0;
        bus.cfg_high   = '0;
`ifdef CLKGEN_PHASE_SYNC_EN
        bus.sync       = 1'b0;
`endif
        #12;
        check("rst clk_out", 32'(bus.clk_out), 32'h0);
        check("rst wrap", 32'(bus.wrap), 32'h0);
        check("rst pending", 32'(bus.pending), 32'h0);
        check("rst cfg_err", 32'(bus.cfg_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Default settings: f_clk/2 at 50%
        bus.enable[0] = 1'b1;
        expect_run(0, 2, 1, 0, 4);

        // Program disabled ch1: pending one cycle, then applied
        set_cfg(1, 10, 6);
        step();
        clr_cfg();
        check("wr1 pending", 32'(bus.pending), 32'h2);
        check("wr1 cfg_err", 32'(bus.cfg_err), 32'h0);
        step();
        check("wr1 applied", 32'(bus.pending), 32'h0);
        bus.enable[1] = 1'b1;
        expect_run(1, 10, 6, 0, 24);

        // Rewrite while running at cnt=3: current period completes first
        set_cfg(1, 5, 1);
        expect_run(1, 10, 6, 4, 1);
        clr_cfg();
        check("wr2 pending", 32'(bus.pending), 32'h2);
        expect_run(1, 10, 6, 5, 5);
        check("wr2 still pending", 32'(bus.pending), 32'h2);
        expect_run(1, 5, 1, 0, 10);
        check("wr2 applied", 32'(bus.pending), 32'h0);

        // Rejected writes
        for (int k = 0; k < 4; k++) begin
            set_cfg(bad_ch[k], bad_period[k], bad_high[k]);
            step();
            clr_cfg();
            check($sformatf("bad%0d cfg_err", k), 32'(bus.cfg_err), 32'h1);
            check($sformatf("bad%0d pending", k), 32'(bus.pending), 32'h0);
            check($sformatf("bad%0d clk_out[2]", k), 32'(bus.clk_out[2]), 32'h0);
            step();
            check($sformatf("bad%0d err clears", k), 32'(bus.cfg_err), 32'h0);
        end

        // Ch2 period 8 high 5, drop enable at cnt=4, then re-enable
        set_cfg(2, 8, 5);
        step();
        clr_cfg();
        check("wr3 pending", 32'(bus.pending), 32'h4);
        step();
        check("wr3 applied", 32'(bus.pending), 32'h0);
        bus.enable[2] = 1'b1;
        expect_run(2, 8, 5, 0, 5);
        bus.enable[2] = 1'b0;
        step();
        check("dis clk_out[2]", 32'(bus.clk_out[2]), 32'h0);
        check("dis wrap[2]", 32'(bus.wrap[2]), 32'h0);
        step();
        check("dis clk_out[2] hold", 32'(bus.clk_out[2]), 32'h0);
        bus.enable[2] = 1'b1;
        expect_run(2, 8, 5, 0, 10);

        // Asynchronous reset mid-period, away from any clock edge
        rst = 1'b1;
        #1;
        check("async rst clk_out", 32'(bus.clk_out), 32'h0);
        check("async rst wrap", 32'(bus.wrap), 32'h0);
        #2;
        rst = 1'b0;
        expect_run(2, 2, 1, 0, 4);

`ifdef CLKGEN_PHASE_SYNC_EN
        bus.enable = '0;
        set_cfg(0, 6, 3);
        step();
        set_cfg(1, 9, 4);
        step();
        clr_cfg();
        step();
        check("sync cfg applied", 32'(bus.pending), 32'h0);
        bus.enable[0] = 1'b1;
        step();
        step();
        bus.enable[1] = 1'b1;
        expect_run(1, 9, 4, 0, 3);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check("sync wrap", 32'(bus.wrap[1:0]), 32'h3);
        check("sync clk_out", 32'(bus.clk_out[1:0]), 32'h3);
        expect_run(0, 6, 3, 1, 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
